// File: rtl/sequenciador_notas.sv
// Synchronizes, debounces and priority-encodes seven note keys plus a tone key into {TOM_module, NOTAS}.
// Define SEQ_PLAYBACK_EN to build the 8-entry record/playback buffer (GRAVAR/TOCAR/LIMPAR, CHEIO, TOCANDO).
module sequenciador_notas #(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int PASSO_CICLOS    = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] TECLAS,
    input  logic       TECLA_TOM,
    input  logic       GRAVAR,
    input  logic       TOCAR,
    input  logic       LIMPAR,
    output logic [2:0] NOTAS,
    output logic       TOM_module,
    output logic       VALIDO,
    output logic       CHEIO,
    output logic       TOCANDO
);
    localparam int CW  = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam int LIM = (DEBOUNCE_CICLOS >= 2) ? DEBOUNCE_CICLOS - 2 : 0;

    typedef enum logic [1:0] {S_OCIOSO, S_FILTRANDO, S_SEGURANDO, S_TOCANDO} estado_t;

    estado_t        state;
    logic [7:0]     sync1, sync2;
    logic [3:0]     latched;
    logic [CW-1:0]  cnt;
    logic [2:0]     code;
    logic           none;
    logic [3:0]     cand;
    logic           filt_done;
    logic           accept;
    logic           play_start;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {TECLA_TOM, TECLAS};
            sync2 <= sync1;
        end
    end

    always_comb begin
        code = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (sync2[i]) code = 3'(i);
        end
    end

    assign none      = ~|sync2[6:0];
    assign cand      = {sync2[7], code};
    // Entering FILTRANDO already counts as the first stable cycle, hence the D-2 limit.
    assign filt_done = (DEBOUNCE_CICLOS <= 1) || (cnt == CW'(LIM));
    assign accept    = !none && (((state == S_FILTRANDO) && (cand == latched) && filt_done) ||
                                 ((state == S_OCIOSO) && (DEBOUNCE_CICLOS == 1) && !play_start));

`ifdef SEQ_PLAYBACK_EN
    localparam int PW = $clog2(PASSO_CICLOS) + 1;

    logic          toc1, toc2, toc3;
    logic [3:0]    mem [8];
    logic [3:0]    count;
    logic [2:0]    idx;
    logic [PW-1:0] passo;
    logic          wr_en;
    logic          last_step;

    assign play_start = (state == S_OCIOSO) && toc2 && !toc3 && (count != 4'd0) && !LIMPAR;
    assign wr_en      = accept && GRAVAR && !LIMPAR && (count != 4'd8);
    assign last_step  = (({1'b0, idx} + 4'd1) == count);

    always_ff @(posedge CLK) begin
        if (wr_en) mem[count[2:0]] <= cand;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            toc1  <= 1'b0;
            toc2  <= 1'b0;
            toc3  <= 1'b0;
            count <= 4'd0;
            CHEIO <= 1'b0;
        end else begin
            toc1 <= TOCAR;
            toc2 <= toc1;
            toc3 <= toc2;
            if (LIMPAR) begin
                count <= 4'd0;
                CHEIO <= 1'b0;
            end else if (wr_en) begin
                count <= count + 4'd1;
                CHEIO <= (count == 4'd7);
            end
        end
    end
`else
    logic unused_ctrl;

    assign play_start  = 1'b0;
    assign CHEIO       = 1'b0;
    assign TOCANDO     = 1'b0;
    assign unused_ctrl = &{1'b0, GRAVAR, TOCAR, LIMPAR, PASSO_CICLOS[0]};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_OCIOSO;
            latched    <= 4'd0;
            cnt        <= '0;
            NOTAS      <= 3'd0;
            TOM_module <= 1'b0;
            VALIDO     <= 1'b0;
`ifdef SEQ_PLAYBACK_EN
            idx        <= 3'd0;
            passo      <= '0;
            TOCANDO    <= 1'b0;
`endif
        end else begin
            case (state)
                S_OCIOSO: begin
`ifdef SEQ_PLAYBACK_EN
                    if (play_start) begin
                        state                <= S_TOCANDO;
                        idx                  <= 3'd0;
                        passo                <= '0;
                        {TOM_module, NOTAS}  <= mem[0];
                        VALIDO               <= 1'b1;
                        TOCANDO              <= 1'b1;
                    end else
`endif
                    if (accept) begin
                        state               <= S_SEGURANDO;
                        latched             <= cand;
                        {TOM_module, NOTAS} <= cand;
                        VALIDO              <= 1'b1;
                    end else if (!none) begin
                        state   <= S_FILTRANDO;
                        latched <= cand;
                        cnt     <= '0;
                    end
                end
                S_FILTRANDO: begin
                    if (none) begin
                        state <= S_OCIOSO;
                    end else if (cand != latched) begin
                        latched <= cand;
                        cnt     <= '0;
                    end else if (filt_done) begin
                        state               <= S_SEGURANDO;
                        {TOM_module, NOTAS} <= cand;
                        VALIDO              <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SEGURANDO: begin
                    if (none) begin
                        state  <= S_OCIOSO;
                        VALIDO <= 1'b0;
                    end else if (cand != latched) begin
                        state   <= S_FILTRANDO;
                        latched <= cand;
                        cnt     <= '0;
                        VALIDO  <= 1'b0;
                    end
                end
                S_TOCANDO: begin
`ifdef SEQ_PLAYBACK_EN
                    if (LIMPAR) begin
                        state   <= S_OCIOSO;
                        VALIDO  <= 1'b0;
                        TOCANDO <= 1'b0;
                    end else if (passo == PW'(PASSO_CICLOS - 1)) begin
                        passo <= '0;
                        if (last_step) begin
                            state   <= S_OCIOSO;
                            VALIDO  <= 1'b0;
                            TOCANDO <= 1'b0;
                        end else begin
                            idx                 <= idx + 3'd1;
                            {TOM_module, NOTAS} <= mem[idx + 3'd1];
                        end
                    end else begin
                        passo <= passo + PW'(1);
                    end
`else
                    state <= S_OCIOSO;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequenciador_notas.sv
// Self-checking bench for sequenciador_notas: directed cases plus random key/playback traffic
// compared every cycle against a run-length/queue reference model.
module tb_sequenciador_notas;
    localparam int D = 16;
    localparam int P = 64;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [6:0] TECLAS = 7'd0;
    logic       TECLA_TOM = 1'b0;
    logic       GRAVAR = 1'b0;
    logic       TOCAR = 1'b0;
    logic       LIMPAR = 1'b0;
    logic [2:0] NOTAS;
    logic       TOM_module, VALIDO, CHEIO, TOCANDO;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0] hk0, hk1;
    logic       ht0, ht1, ht2;
    int         run;
    logic [3:0] last;
    logic       m_valid;
    logic [3:0] m_out;
    logic [3:0] mq[$];
    logic       playing;
    int         pidx, pstep;

    always #5 CLK = ~CLK;

    sequenciador_notas #(.DEBOUNCE_CICLOS(D), .PASSO_CICLOS(P)) dut (
        .CLK(CLK), .RST(RST), .TECLAS(TECLAS), .TECLA_TOM(TECLA_TOM),
        .GRAVAR(GRAVAR), .TOCAR(TOCAR), .LIMPAR(LIMPAR),
        .NOTAS(NOTAS), .TOM_module(TOM_module), .VALIDO(VALIDO),
        .CHEIO(CHEIO), .TOCANDO(TOCANDO)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lowest_key(input logic [7:0] raw);
        for (int i = 0; i < 7; i++) begin
            if (raw[i]) return {raw[7], 3'(i)};
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        hk0 = 8'd0; hk1 = 8'd0;
        ht0 = 1'b0; ht1 = 1'b0; ht2 = 1'b0;
        run = 0; last = 4'd0;
        m_valid = 1'b0; m_out = 4'd0;
        mq.delete();
        playing = 1'b0; pidx = 0; pstep = 0;
    endtask

    // One clock edge: keys seen by the filter are the raw values from two edges earlier.
    task automatic model_step();
        logic [3:0] c;
        logic       key_none;
        logic       rise;
        c        = lowest_key(hk1);
        key_none = (hk1[6:0] == 7'd0);
        rise     = ht1 && !ht2;
`ifdef SEQ_PLAYBACK_EN
        if (playing) begin
            run = 0;
            if (LIMPAR) begin
                playing = 1'b0; m_valid = 1'b0;
            end else if (pstep == P - 1) begin
                pstep = 0;
                pidx++;
                if (pidx == mq.size()) begin
                    playing = 1'b0; m_valid = 1'b0;
                end else begin
                    m_out = mq[pidx];
                end
            end else begin
                pstep++;
            end
        end else if (rise && run == 0 && mq.size() > 0 && !LIMPAR) begin
            playing = 1'b1; pidx = 0; pstep = 0;
            m_out = mq[0]; m_valid = 1'b1; run = 0;
        end else
`endif
        begin
            if (key_none) begin
                run = 0; m_valid = 1'b0;
            end else begin
                if (run == 0 || c != last) begin
                    run = 1; last = c; m_valid = 1'b0;
                end else if (run <= D) begin
                    run++;
                end
                if (run == D) begin
                    m_valid = 1'b1; m_out = c;
`ifdef SEQ_PLAYBACK_EN
                    if (GRAVAR && !LIMPAR && mq.size() < 8) mq.push_back(c);
`endif
                end
            end
        end
`ifdef SEQ_PLAYBACK_EN
        if (LIMPAR) mq.delete();
`endif
        hk1 = hk0; hk0 = {TECLA_TOM, TECLAS};
        ht2 = ht1; ht1 = ht0; ht0 = TOCAR;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) model_reset();
        else model_step();
        #1;
        chk("outs", {TOCANDO, CHEIO, VALIDO, TOM_module, NOTAS},
            {playing, (mq.size() == 8), m_valid, m_out});
    endtask

    task automatic do_reset();
        #2 RST = 1'b1;
        #1;
        model_reset();
        chk("rst_async", {TOCANDO, CHEIO, VALIDO, TOM_module, NOTAS}, 0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic press(input logic [6:0] k, input logic t);
        TECLAS = k; TECLA_TOM = t;
        repeat (D + 4) tick();
        TECLAS = 7'd0; TECLA_TOM = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        int r;
        int n_hi;
        model_reset();
        #1;
        chk("reset", {TOCANDO, CHEIO, VALIDO, TOM_module, NOTAS}, 0);
        tick(); tick();
        RST = 1'b0;
        tick();

        // press latency and release latency
        TECLAS = 7'b0000100; TECLA_TOM = 1'b1;
        repeat (D + 1) tick();
        chk("press_early", VALIDO, 0);
        tick();
        chk("press_valid", VALIDO, 1);
        chk("press_note", {TOM_module, NOTAS}, 4'hA);
        repeat (5) tick();
        TECLAS = 7'd0; TECLA_TOM = 1'b0;
        tick(); tick();
        chk("release_hold", VALIDO, 1);
        tick();
        chk("release", VALIDO, 0);
        chk("release_note", {TOM_module, NOTAS}, 4'hA);
        repeat (3) tick();

        // bounce shorter than the filter never reaches the output
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) TECLAS[0] = ~TECLAS[0];
            tick();
            chk("bounce", VALIDO, 0);
        end
        TECLAS = 7'b1000001; TECLA_TOM = 1'b0;
        repeat (D + 3) tick();
        chk("prio_valid", VALIDO, 1);
        chk("prio_note", NOTAS, 0);
        TECLAS = 7'd0;
        repeat (5) tick();

`ifdef SEQ_PLAYBACK_EN
        // record three notes and replay them
        LIMPAR = 1'b1; tick(); LIMPAR = 1'b0;
        GRAVAR = 1'b1;
        press(7'b0000010, 1'b0);
        press(7'b0001000, 1'b1);
        press(7'b0100000, 1'b0);
        GRAVAR = 1'b0;
        TOCAR = 1'b1;
        tick(); tick();
        chk("play_wait", TOCANDO, 0);
        tick();
        TOCAR = 1'b0;
        chk("play_start", TOCANDO, 1);
        chk("play_e0", {TOM_module, NOTAS}, 4'd1);
        repeat (P) tick();
        chk("play_e1", {TOM_module, NOTAS}, 4'd11);
        repeat (P) tick();
        chk("play_e2", {TOM_module, NOTAS}, 4'd5);
        chk("play_valid", VALIDO, 1);
        repeat (P - 1) tick();
        chk("play_last", TOCANDO, 1);
        tick();
        chk("play_end", {TOCANDO, VALIDO}, 0);

        // nine writes: eighth fills the buffer, ninth is dropped
        LIMPAR = 1'b1; tick(); LIMPAR = 1'b0;
        GRAVAR = 1'b1;
        for (int i = 0; i < 9; i++) begin
            press(7'(1 << (i % 7)), i[0]);
            if (i == 6) chk("cheio_7", CHEIO, 0);
            if (i == 7) chk("cheio_8", CHEIO, 1);
        end
        GRAVAR = 1'b0;
        chk("cheio_9", CHEIO, 1);
        TOCAR = 1'b1;
        repeat (3) tick();
        TOCAR = 1'b0;
        n_hi = 0;
        for (int k = 0; k < 1000 && TOCANDO; k++) begin
            n_hi++;
            tick();
        end
        chk("play8_len", n_hi, 8 * P);
        chk("cheio_after", CHEIO, 1);

        // LIMPAR aborts playback; later TOCAR with empty buffer is ignored
        TOCAR = 1'b1;
        repeat (3) tick();
        TOCAR = 1'b0;
        repeat (10) tick();
        chk("abort_pre", TOCANDO, 1);
        LIMPAR = 1'b1; tick(); LIMPAR = 1'b0;
        chk("abort", {TOCANDO, VALIDO, CHEIO}, 0);
        TOCAR = 1'b1; repeat (5) tick(); TOCAR = 1'b0;
        repeat (5) tick();
        chk("tocar_empty", TOCANDO, 0);

        // reset mid-playback discards the buffer
        GRAVAR = 1'b1;
        press(7'b0000001, 1'b1);
        press(7'b1000000, 1'b0);
        GRAVAR = 1'b0;
        TOCAR = 1'b1; repeat (3) tick(); TOCAR = 1'b0;
        repeat (20) tick();
        chk("mid_play", TOCANDO, 1);
        do_reset();
        TOCAR = 1'b1; repeat (5) tick(); TOCAR = 1'b0;
        repeat (5) tick();
        chk("post_rst_play", TOCANDO, 0);
`endif

        // reset mid-filter
        TECLAS = 7'b0010000;
        repeat (10) tick();
        do_reset();
        TECLAS = 7'd0;
        repeat (5) tick();

        // random traffic against the model
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            if (r < 2) TECLAS = 7'd0;
            else if (r < 8) TECLAS = 7'(1 << $urandom_range(0, 6));
            else TECLAS = 7'($urandom);
            TECLA_TOM = 1'($urandom);
            GRAVAR    = 1'($urandom);
            LIMPAR    = ($urandom_range(0, 19) == 0);
            TOCAR     = ($urandom_range(0, 5) == 0);
            repeat ($urandom_range(1, 30)) tick();
        end
        TECLAS = 7'd0; TECLA_TOM = 1'b0; GRAVAR = 1'b0; LIMPAR = 1'b0; TOCAR = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
